rr_req_arbiter: RTL and testbench

Parametrised multi-channel request/grant arbiter and the successor to the single-channel req/gnt block. It accepts N independent request lines and issues at most one registered, one-hot grant. Requesters are served round-robin, and a hold-timeout forces the grant to rotate when other requesters are waiting. It sits between N bus masters and one shared resource, and its property module binds to the same clk/req/gnt port names.

---
 rtl/rr_req_arbiter.sv | 113 +++++++++++
 tb/tb_rr_req_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_req_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rr_req_arbiter                                             |
// | Description : N-channel round-robin request/grant arbiter with registered |
// |               one-hot grant and hold-timeout preemption.                 |
// | Revision    : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
module rr_req_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [N-1:0]                         req,
  output logic [N-1:0]                         gnt,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] gnt_id,
  output logic                                 preempt
);

  localparam int c_id_w = (N > 1) ? $clog2(N) : 1;
  localparam int c_hc_w = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [c_hc_w-1:0] c_max_hold = c_hc_w'(MAX_HOLD);
  localparam logic [c_hc_w-1:0] c_hold_one = c_hc_w'(1);
  localparam logic [c_id_w-1:0] c_last_id  = c_id_w'(N - 1);
  localparam logic [c_id_w-1:0] c_id_one   = c_id_w'(1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t              r_state;
  logic [c_id_w-1:0]   r_ptr;
  logic [c_hc_w-1:0]   r_hold_cnt;
  logic [N-1:0]        r_gnt;
  logic [c_id_w-1:0]   r_gnt_id;
  logic                r_preempt;

  logic                w_win_found;
  logic [c_id_w-1:0]   w_win_id;
  logic [N-1:0]        w_win_onehot;
  logic [c_id_w-1:0]   w_next_ptr;
  logic                w_owner_req;
  logic                w_others_req;
  logic                w_timeout;

  // First set request bit searching upward from r_ptr, wrapping modulo N.
  always_comb begin
    w_win_found  = 1'b0;
    w_win_id     = '0;
    w_win_onehot = '0;
    for (int i = 0; i < N; i++) begin
      if (!w_win_found && req[(int'(r_ptr) + i) % N]) begin
        w_win_found = 1'b1;
        w_win_id    = c_id_w'((int'(r_ptr) + i) % N);
      end
    end
    for (int j = 0; j < N; j++) begin
      w_win_onehot[j] = w_win_found && (w_win_id == c_id_w'(j));
    end
  end

  assign w_next_ptr   = (w_win_id == c_last_id) ? '0 : (w_win_id + c_id_one);
  // r_gnt is one-hot while granted, so it doubles as the owner mask.
  assign w_owner_req  = |(req & r_gnt);
  assign w_others_req = |(req & ~r_gnt);
  assign w_timeout    = (MAX_HOLD != 0) && (r_hold_cnt == c_max_hold) && w_others_req;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_hold_cnt <= '0;
      r_gnt      <= '0;
      r_gnt_id   <= '0;
      r_preempt  <= 1'b0;
    end else begin
      r_preempt <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_win_found) begin
            r_gnt      <= w_win_onehot;
            r_gnt_id   <= w_win_id;
            r_hold_cnt <= c_hold_one;
            r_ptr      <= w_next_ptr;
            r_state    <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (!w_owner_req || w_timeout) begin
            r_gnt     <= '0;
            r_gnt_id  <= '0;
            r_preempt <= w_owner_req;
            r_state   <= ST_IDLE;
          end else if (r_hold_cnt < c_max_hold) begin
            r_hold_cnt <= r_hold_cnt + c_hold_one;
          end
        end
        default: begin
          r_gnt    <= '0;
          r_gnt_id <= '0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt     = r_gnt;
  assign gnt_id  = r_gnt_id;
  assign preempt = r_preempt;

endmodule
`default_nettype wire

// File: tb/tb_rr_req_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_rr_req_arbiter                                          |
// | Description : Directed self-checking bench for rr_req_arbiter (N=4 and 1)|
// | Revision    : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
module tb_rr_req_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       preempt;
  logic [0:0] req1;
  logic [0:0] gnt1;
  logic [0:0] gnt_id1;
  logic       preempt1;

  int checks;
  int errors;

  rr_req_arbiter #(.N(4), .MAX_HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .gnt_id(gnt_id), .preempt(preempt)
  );

  rr_req_arbiter #(.N(1), .MAX_HOLD(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .gnt(gnt1), .gnt_id(gnt_id1), .preempt(preempt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'b1111;
    req1  = 1'b1;
    for (int e = 0; e < 2; e++) begin
      tick();
      checks++;
      if ({gnt, gnt_id, preempt} !== 7'b0) begin
        errors++;
        $display("FAIL reset_outputs edge%0d got gnt=%b id=%0d pre=%b want 0000/0/0", e, gnt, gnt_id, preempt);
      end
      checks++;
      if ({gnt1, preempt1} !== 2'b0) begin
        errors++;
        $display("FAIL reset_n1 edge%0d got gnt=%b pre=%b want 0/0", e, gnt1, preempt1);
      end
    end
    rst_n = 1'b1;
    req1  = 1'b0;
    tick();
    checks++;
    if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin
      errors++;
      $display("FAIL reset_first_grant got gnt=%b id=%0d want 0001/0", gnt, gnt_id);
    end
    req = 4'b0000;
    tick();
    checks++;
    if (gnt !== 4'b0000) begin
      errors++;
      $display("FAIL reset_release got gnt=%b want 0000", gnt);
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (gnt !== 4'b0100 || gnt_id !== 2'd2 || preempt !== 1'b0) begin
        errors++;
        $display("FAIL single_grant cyc%0d got gnt=%b id=%0d pre=%b want 0100/2/0", c, gnt, gnt_id, preempt);
      end
    end
    req = 4'b0000;
    tick();
    checks++;
    if (gnt !== 4'b0000 || gnt_id !== 2'd0) begin
      errors++;
      $display("FAIL single_release got gnt=%b id=%0d want 0000/0", gnt, gnt_id);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req = 4'b0001;
    tick();
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL b2b_first got gnt=%b want 0001", gnt);
    end
    req = 4'b0010;
    tick();
    checks++;
    if (gnt !== 4'b0000 || preempt !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap got gnt=%b pre=%b want 0000/0", gnt, preempt);
    end
    tick();
    checks++;
    if (gnt !== 4'b0010 || gnt_id !== 2'd1) begin
      errors++;
      $display("FAIL b2b_second got gnt=%b id=%0d want 0010/1", gnt, gnt_id);
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_saturated();
    logic [3:0] exp_gnt;
    logic [1:0] exp_id;
    logic       exp_pre;
    int         slot;
    int         pos;
    do_reset();
    req = 4'b1111;
    for (int c = 0; c < 21; c++) begin
      tick();
      slot = (c / 5) % 4;
      pos  = c % 5;
      if (pos < 4) begin
        exp_gnt = 4'b0001 << slot;
        exp_id  = 2'(slot);
        exp_pre = 1'b0;
      end else begin
        exp_gnt = 4'b0000;
        exp_id  = 2'd0;
        exp_pre = 1'b1;
      end
      checks++;
      if (gnt !== exp_gnt || gnt_id !== exp_id || preempt !== exp_pre) begin
        errors++;
        $display("FAIL saturated cyc%0d got gnt=%b id=%0d pre=%b want %b/%0d/%b",
                 c, gnt, gnt_id, preempt, exp_gnt, exp_id, exp_pre);
      end
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_lone_holder();
    do_reset();
    req = 4'b0010;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (gnt !== 4'b0010 || preempt !== 1'b0) begin
        errors++;
        $display("FAIL lone_hold cyc%0d got gnt=%b pre=%b want 0010/0", c, gnt, preempt);
      end
    end
    req = 4'b1010;
    tick();
    checks++;
    if (gnt !== 4'b0000 || preempt !== 1'b1) begin
      errors++;
      $display("FAIL lone_preempt got gnt=%b pre=%b want 0000/1", gnt, preempt);
    end
    tick();
    checks++;
    if (gnt !== 4'b1000 || gnt_id !== 2'd3 || preempt !== 1'b0) begin
      errors++;
      $display("FAIL lone_handover got gnt=%b id=%0d pre=%b want 1000/3/0", gnt, gnt_id, preempt);
    end
  endtask

  task automatic test_reset_mid_grant();
    req = 4'b1000;
    tick();
    checks++;
    if (gnt !== 4'b1000) begin
      errors++;
      $display("FAIL midrst_pre got gnt=%b want 1000", gnt);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (gnt !== 4'b0000 || gnt_id !== 2'd0 || preempt !== 1'b0) begin
      errors++;
      $display("FAIL midrst_clear got gnt=%b id=%0d pre=%b want 0000/0/0", gnt, gnt_id, preempt);
    end
    rst_n = 1'b1;
    req   = 4'b1001;
    tick();
    checks++;
    if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin
      errors++;
      $display("FAIL midrst_ptr0 got gnt=%b id=%0d want 0001/0", gnt, gnt_id);
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_n1();
    logic [0:0] pat [8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [0:0] expg [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      req1 = pat[c];
      tick();
      checks++;
      if (gnt1 !== expg[c] || gnt_id1 !== 1'b0 || preempt1 !== 1'b0) begin
        errors++;
        $display("FAIL n1_seq cyc%0d got gnt=%b id=%b pre=%b want %b/0/0", c, gnt1, gnt_id1, preempt1, expg[c]);
      end
    end
    req1 = 1'b0;
    tick();
    checks++;
    if (gnt1 !== 1'b0) begin
      errors++;
      $display("FAIL n1_release got gnt=%b want 0", gnt1);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    req    = 4'b0000;
    req1   = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_saturated();
    test_lone_holder();
    test_reset_mid_grant();
    test_n1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
